// File: rtl/dmem_responder.sv
// Data-side responder: word RAM, machine-timer MMIO window and unmapped space.
// Optional bus-error capture (ERR flag, ERRADDR register) is enabled by defining DMEM_BUSERR_EN.
module dmem_responder #(
  parameter int unsigned DEPTH     = 4096,
  parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
  parameter logic [31:0] MMIO_BASE = 32'h1000_0000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ram_req_i,
  input  logic        ram_we_i,
  input  logic [31:0] ram_addr_i,
  input  logic [31:0] ram_wdata_i,
  output logic [31:0] ram_data_o,
  output logic        timer_irq_o
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam int unsigned PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX    = PW'(PRESCALE - 1);
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH) << 2;

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   ram_off_s;
  logic [AW-1:0] ram_idx_s;
  logic          ram_hit_s;
  logic          mmio_hit_s;
  logic [2:0]    mmio_off_s;
  logic          rd_s;
  logic          wr_s;
  logic          rd_mmio_s;
  logic          wr_mmio_s;
  logic          tick_s;
  logic [31:0]   ctrl_rd_s;

  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   mtimecmp_q, mtimecmp_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [31:0]   hi_shadow_q, hi_shadow_d;
  logic          en_q, en_d;
  logic          irq_q, irq_d;
  logic          err_s;
`ifdef DMEM_BUSERR_EN
  logic          err_q, err_d;
  logic [31:0]   erraddr_q, erraddr_d;
  logic          bad_s;
  logic          err_clr_s;
`endif

  // RAM hit is checked by offset from the base so a base near the top of memory still decodes
  assign ram_off_s  = ram_addr_i - RAM_BASE;
  assign ram_hit_s  = ({1'b0, ram_off_s} < RAM_BYTES);
  assign ram_idx_s  = ram_off_s[AW+1:2];
  assign mmio_hit_s = !ram_hit_s && (ram_addr_i[31:5] == MMIO_BASE[31:5]);
  assign mmio_off_s = ram_addr_i[4:2];
  assign rd_s       = ram_req_i && !ram_we_i;
  assign wr_s       = ram_req_i && ram_we_i;
  assign rd_mmio_s  = rd_s && mmio_hit_s;
  assign wr_mmio_s  = wr_s && mmio_hit_s;
  assign tick_s     = en_q && (pcnt_q == PMAX);
  assign timer_irq_o = irq_q;

`ifdef DMEM_BUSERR_EN
  assign err_s     = err_q;
  assign bad_s     = ram_req_i && !ram_hit_s && !mmio_hit_s;
  assign err_clr_s = wr_mmio_s && (mmio_off_s == 3'd4) && ram_wdata_i[2];
`else
  assign err_s     = 1'b0;
`endif

  assign ctrl_rd_s = {29'd0, err_s, irq_q, en_q};

  // RAM array: no reset, writes commit even while rst_i is high
  always_ff @(posedge clk_i) begin
    if (wr_s && ram_hit_s) begin
      mem_q[ram_idx_s] <= ram_wdata_i;
    end
  end

  // Zero-latency read mux
  always_comb begin
    ram_data_o = 32'h0000_0000;
    if (rd_s && ram_hit_s) begin
      ram_data_o = mem_q[ram_idx_s];
    end else if (rd_mmio_s) begin
      case (mmio_off_s)
        3'd0:    ram_data_o = mtime_q[31:0];
        3'd1:    ram_data_o = hi_shadow_q;
        3'd2:    ram_data_o = mtimecmp_q[31:0];
        3'd3:    ram_data_o = mtimecmp_q[63:32];
        3'd4:    ram_data_o = ctrl_rd_s;
`ifdef DMEM_BUSERR_EN
        3'd5:    ram_data_o = erraddr_q;
`endif
        default: ram_data_o = 32'h0000_0000;
      endcase
    end else begin
      ram_data_o = 32'h0000_0000;
    end
  end

  // Timer next state; a software write to one mtime half overrides that cycle's increment
  always_comb begin
    pcnt_d      = pcnt_q;
    mtime_d     = mtime_q;
    mtimecmp_d  = mtimecmp_q;
    hi_shadow_d = hi_shadow_q;
    en_d        = en_q;
    irq_d       = en_q && (mtime_q >= mtimecmp_q);
    if (tick_s) begin
      pcnt_d  = {PW{1'b0}};
      mtime_d = mtime_q + 64'd1;
    end else if (en_q) begin
      pcnt_d  = pcnt_q + PW'(1'b1);
    end else begin
      pcnt_d  = pcnt_q;
    end
    if (rd_mmio_s && (mmio_off_s == 3'd0)) begin
      hi_shadow_d = mtime_q[63:32];
    end else begin
      hi_shadow_d = hi_shadow_q;
    end
    if (wr_mmio_s) begin
      case (mmio_off_s)
        3'd0:    mtime_d = {mtime_q[63:32], ram_wdata_i};
        3'd1:    mtime_d = {ram_wdata_i, mtime_q[31:0]};
        3'd2:    mtimecmp_d = {mtimecmp_q[63:32], ram_wdata_i};
        3'd3:    mtimecmp_d = {ram_wdata_i, mtimecmp_q[31:0]};
        3'd4:    en_d = ram_wdata_i[0];
        default: en_d = en_q;
      endcase
    end else begin
      en_d = en_q;
    end
  end

`ifdef DMEM_BUSERR_EN
  // Sticky error capture; a fresh error beats a clear landing on the same edge
  always_comb begin
    err_d     = err_q;
    erraddr_d = erraddr_q;
    if (bad_s && (!err_q || err_clr_s)) begin
      err_d     = 1'b1;
      erraddr_d = ram_addr_i;
    end else if (err_clr_s) begin
      err_d     = 1'b0;
    end else begin
      err_d     = err_q;
    end
  end

  // Error registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q     <= 1'b0;
      erraddr_q <= 32'h0000_0000;
    end else begin
      err_q     <= err_d;
      erraddr_q <= erraddr_d;
    end
  end
`endif

  // Timer registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mtime_q     <= 64'd0;
      mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
      pcnt_q      <= {PW{1'b0}};
      hi_shadow_q <= 32'h0000_0000;
      en_q        <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      pcnt_q      <= pcnt_d;
      hi_shadow_q <= hi_shadow_d;
      en_q        <= en_d;
      irq_q       <= irq_d;
    end
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-side responder for the core's RAM request port. Decodes each request into one of three targets: word RAM, a machine-timer MMIO block, or unmapped space.
- Returns read data in the same cycle. Commits writes on the clock edge.
- Drives a timer interrupt line toward the core/CSR logic.
- Sits in the SoC top between the core RAM port and the memory/peripheral fabric.

Parameters:
- DEPTH, 4096: RAM size in 32-bit words; power of two.
- RAM_BASE, 32'h0000_0000: byte base address of RAM.
- MMIO_BASE, 32'h1000_0000: byte base address of the 32-byte timer window.
- PRESCALE, 1: clock cycles per mtime increment; must be >= 1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- ram_req_i  in  1  access request valid
- ram_we_i  in  1  1 = write, 0 = read; ignored when ram_req_i=0
- ram_addr_i  in  32  byte address; bits [1:0] ignored, word accesses only
- ram_wdata_i  in  32  write data
- ram_data_o  out  32  read data, combinational
- timer_irq_o  out  1  registered timer interrupt level

Interface (already decided):
- One clock.
- Reset is synchronous and active-high.
- Clock port is clk_i; reset port is rst_i.

Behaviour:

Address decode:
- RAM hit: (addr - RAM_BASE) < DEPTH*4. Word index = (addr - RAM_BASE) >> 2.
- MMIO hit: addr[31:5] == MMIO_BASE[31:5]. Offset = addr[4:2].
- Anything else is unmapped.

Reads:
- ram_data_o is valid in the same cycle when ram_req_i=1 and ram_we_i=0. Latency 0.
- ram_data_o = 0 when there is no read request, and for any unmapped or reserved-offset read.

Writes:
- Take effect at the rising edge in which ram_req_i=1 and ram_we_i=1.
- A read of the same address in the next cycle returns the new value.
- Writes to unmapped addresses or reserved offsets are dropped.

RAM:
- Word array; contents are not affected by reset.

MMIO offsets:
- 0 MTIME_LO, r/w.
- 1 MTIME_HI, r/w. A read returns hi_shadow.
- 2 MTIMECMP_LO, r/w.
- 3 MTIMECMP_HI, r/w.
- 4 CTRL: bit0 EN, r/w; bit1 PEND, read-only, mirrors timer_irq_o; other bits read 0.
- 5-7 reserved: read 0, writes ignored.

Timer state:
- 64-bit mtime, 64-bit mtimecmp, prescale counter pcnt.
- PRESCALE counts 0..PRESCALE-1.

Counting:
- When EN=1, pcnt increments each cycle.
- On the cycle pcnt == PRESCALE-1, pcnt wraps to 0 and mtime increments by 1. The 64-bit increment wraps from all-ones to 0.
- When EN=0, pcnt and mtime hold.

Simultaneous events:
- A software write to MTIME_LO or MTIME_HI in the same cycle as an increment wins. The written half takes the written value; the other half holds (no carry applied). pcnt still advances.
- Writing EN=0 stops counting from the next cycle.

Coherent 64-bit read:
- A read of MTIME_LO latches the current mtime[63:32] into hi_shadow at that clock edge.
- A MTIME_HI read returns hi_shadow.
- hi_shadow is updated only by MTIME_LO reads.

Interrupt:
- timer_irq_o is registered: next value = EN && (mtime >= mtimecmp), unsigned 64-bit compare, evaluated on current-cycle register values.
- Visible one cycle after the condition becomes true. Clears one cycle after mtimecmp is raised above mtime or EN is cleared.

Reset values:
- mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, EN = 0, pcnt = 0, hi_shadow = 0, timer_irq_o = 0.
- ram_data_o is 0 unless a read is in progress.
- Reset asserted mid-operation overrides all writes and increments in that cycle. RAM writes in that cycle are still committed.

Optional Feature:
- Macro DMEM_BUSERR_EN.
- When defined:
  - Offset 5 becomes ERRADDR (read-only, reset 0).
  - CTRL bit2 becomes ERR (sticky, reset 0; writing 1 to bit2 clears it).
  - Any request to an unmapped address sets ERR and captures ram_addr_i into ERRADDR on that edge. First error wins while ERR=1.
  - If clear and a new error occur in the same cycle, the new error wins.
- When undefined: offset 5 is reserved, CTRL bit2 reads 0, and unmapped accesses are silently ignored.

Test Plan:
1. Reset, write 32'hDEADBEEF to RAM_BASE+8, read it in the next cycle -> ram_data_o=32'hDEADBEEF. Read RAM_BASE+DEPTH*4 -> 0.
2. With PRESCALE=1: write CTRL=1, idle 10 cycles, read MTIME_LO -> 10 (±1 for the sampling cycle, checked exactly against the model).
3. Write MTIME_LO=32'hFFFF_FFFF, MTIME_HI=0, EN=1. After 1 increment, read MTIME_LO=0 then MTIME_HI -> 1 (shadow latched by the LO read).
4. Write MTIMECMP=20, EN=1 from mtime=0 -> timer_irq_o rises exactly one cycle after mtime reaches 20. Write MTIMECMP_LO=1000 -> irq clears the next cycle. Write EN=0 -> irq low and mtime holds.
5. Write MTIME_LO=5 in the same cycle as a scheduled increment -> read returns 5 (the write wins). Assert rst_i mid-count -> mtime=0, irq=0, CTRL=0 on the next cycle.
6. With DMEM_BUSERR_EN defined: read 32'h2000_0000 -> CTRL bit2=1, ERRADDR=32'h2000_0000. A second bad access at 32'h3000_0000 leaves ERRADDR unchanged. Write CTRL bit2=1 -> ERR=0.
